baud_tx_queue: RTL and testbench

- Buffers 7-bit characters from a producer and feeds them one at a time to the baud sender.
- Sits directly upstream of the sender:
  - drives the sender's data and new-data inputs;
  - watches the sender's busy output.
- Lets producers write bursts without tracking line timing.
- Retries a character if the sender never acknowledges it.

---
 rtl/baud_tx_queue.sv | 177 +++++++++++++++++
 tb/tb_baud_tx_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tx_queue.sv
// Character FIFO in front of the baud sender: issues one character per handshake
// and re-issues the same character when the sender never raises busy.
module baud_tx_queue #(
   parameter int DATA_WIDTH  = 7,
   parameter int DEPTH       = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  busy,
   output logic [DATA_WIDTH-1:0] send_data,
   output logic                  send_new_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                  overflow,
   input  logic                  clear_overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(ACK_TIMEOUT);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic [DATA_WIDTH-1:0] send_data_q, send_data_d;
   logic                  send_new_data_q, send_new_data_d;
   logic                  overflow_q, overflow_d;
   logic                  push_s;
   logic                  pop_s;
   logic                  drop_s;

   // in_ready looks at the pre-edge count, so a full queue rejects even during a pop
   assign in_ready      = (count_q < CNT_FULL);
   assign push_s        = in_valid & in_ready;
   assign drop_s        = in_valid & ~in_ready;
   assign count         = count_q;
   assign send_data     = send_data_q;
   assign send_new_data = send_new_data_q;
   assign overflow      = overflow_q;

   // FIFO bookkeeping: pointers, occupancy and sticky overflow
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      if (clear_overflow) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q | drop_s;
      end
   end

   // Storage array; contents are only meaningful between rd and wr pointers
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic for the issue handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if ((count_q != {CNT_W{1'b0}}) && !busy) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            if (busy) begin
               state_d = WAIT_DONE;
            end else if (timer_q == TMR_LAST) begin
               state_d = ISSUE;
            end else begin
               state_d = WAIT_BUSY;
            end
         end
         WAIT_DONE: begin
            if (!busy) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: strobe, presented character, pop and ack timer
   always_comb begin
      send_data_d     = send_data_q;
      send_new_data_d = 1'b0;
      timer_d         = timer_q;
      pop_s           = 1'b0;
      case (state_q)
         IDLE: begin
            if ((count_q != {CNT_W{1'b0}}) && !busy) begin
               send_data_d     = mem_q[rd_ptr_q];
               send_new_data_d = 1'b1;
               pop_s           = 1'b1;
            end else begin
               send_new_data_d = 1'b0;
            end
         end
         ISSUE: begin
            timer_d = {TMR_W{1'b0}};
         end
         WAIT_BUSY: begin
            if (busy) begin
               send_new_data_d = 1'b0;
            end else if (timer_q == TMR_LAST) begin
               // retry keeps the character already presented; nothing is popped
               send_new_data_d = 1'b1;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end
         WAIT_DONE: begin
            send_new_data_d = 1'b0;
         end
         default: begin
            send_new_data_d = 1'b0;
         end
      endcase
   end

   // Registered datapath state
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wr_ptr_q        <= {PTR_W{1'b0}};
         rd_ptr_q        <= {PTR_W{1'b0}};
         count_q         <= {CNT_W{1'b0}};
         timer_q         <= {TMR_W{1'b0}};
         send_data_q     <= {DATA_WIDTH{1'b0}};
         send_new_data_q <= 1'b0;
         overflow_q      <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         timer_q         <= timer_d;
         send_data_q     <= send_data_d;
         send_new_data_q <= send_new_data_d;
         overflow_q      <= overflow_d;
      end
   end

endmodule

// File: tb/tb_baud_tx_queue.sv
// Directed bench for baud_tx_queue with a simple sender model that holds busy
// for ten cycles after each strobe (or never, for the retry case).
module tb_baud_tx_queue;

   logic       clk;
   logic       rstN;
   logic [6:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       busy;
   logic [6:0] send_data;
   logic       send_new_data;
   logic [3:0] count;
   logic       overflow;
   logic       clear_overflow;

   int         total;
   int         bad;
   int         cyc_n;
   int         busy_cnt;
   int         stab_err;
   int         push_c;
   bit         model_en;
   bit         force_busy;
   logic [6:0] held;
   logic [6:0] strb_q [$];
   int         strb_cyc [$];
   logic [6:0] exp_q [$];

   baud_tx_queue #(.DATA_WIDTH(7), .DEPTH(8), .ACK_TIMEOUT(16)) dut (
      .clk           (clk),
      .rstN          (rstN),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .busy          (busy),
      .send_data     (send_data),
      .send_new_data (send_new_data),
      .count         (count),
      .overflow      (overflow),
      .clear_overflow(clear_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample 1 time unit after the edge, log strobes, step the sender model
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
      if (send_new_data === 1'b1) begin
         held = send_data;
         strb_q.push_back(send_data);
         strb_cyc.push_back(cyc_n);
      end
      if (rstN && busy && (send_data !== held)) stab_err++;
      if (busy_cnt != 0) busy_cnt--;
      if (model_en && (send_new_data === 1'b1)) busy_cnt = 10;
      busy = force_busy || (busy_cnt != 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic push(input logic [6:0] v);
      in_data  = v;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic clr_log();
      strb_q.delete();
      strb_cyc.delete();
   endtask

   initial begin
      total = 0; bad = 0; cyc_n = 0; busy_cnt = 0; stab_err = 0; push_c = 0;
      model_en = 1'b1; force_busy = 1'b0; held = 7'h00;
      rstN = 1'b0; in_data = 7'h00; in_valid = 1'b0; busy = 1'b0; clear_overflow = 1'b0;

      // reset state
      run(2);
      chk("rst_count", count, 4'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_strobe", send_new_data, 1'b0);
      chk("rst_send_data", send_data, 7'h00);
      chk("rst_overflow", overflow, 1'b0);
      rstN = 1'b1;
      run(2);

      // single character latency
      clr_log();
      push(7'h59);
      push_c = cyc_n;
      chk("t1_count_after_push", count, 4'd1);
      chk("t1_no_strobe_yet", send_new_data, 1'b0);
      cyc();
      chk("t1_strobe", send_new_data, 1'b1);
      chk("t1_data", send_data, 7'h59);
      chk("t1_count_popped", count, 4'd0);
      cyc();
      chk("t1_strobe_one_cycle", send_new_data, 1'b0);
      run(14);
      chk("t1_strobe_total", strb_q.size(), 1);
      chk("t1_latency", strb_cyc[0] - push_c, 1);

      // three back-to-back characters, 12-cycle issue spacing with 10-cycle busy
      clr_log();
      push(7'h01);
      push(7'h02);
      push(7'h03);
      run(45);
      chk("t2_strobes", strb_q.size(), 3);
      chk("t2_c0", strb_q[0], 7'h01);
      chk("t2_c1", strb_q[1], 7'h02);
      chk("t2_c2", strb_q[2], 7'h03);
      chk("t2_gap01", strb_cyc[1] - strb_cyc[0], 12);
      chk("t2_gap12", strb_cyc[2] - strb_cyc[1], 12);
      chk("t2_count_empty", count, 4'd0);

      // fill, overflow, sticky flag, clear priority, then drain in order
      clr_log();
      force_busy = 1'b1;
      busy = 1'b1;
      for (int i = 0; i < 8; i++) push(7'h10 + 7'(i));
      chk("t3_count_full", count, 4'd8);
      chk("t3_not_ready", in_ready, 1'b0);
      push(7'h7F);
      chk("t3_count_after_drop", count, 4'd8);
      chk("t3_overflow_set", overflow, 1'b1);
      cyc();
      chk("t3_overflow_sticky", overflow, 1'b1);
      clear_overflow = 1'b1;
      push(7'h7E);
      clear_overflow = 1'b0;
      chk("t3_clear_beats_set", overflow, 1'b0);
      chk("t3_count_still_full", count, 4'd8);
      cyc();
      chk("t3_overflow_stays_clear", overflow, 1'b0);
      chk("t3_no_issue_while_busy", strb_q.size(), 0);
      force_busy = 1'b0;
      busy = (busy_cnt != 0);
      for (int k = 0; k < 200 && strb_q.size() < 8; k++) cyc();
      run(15);
      chk("t3_drained", strb_q.size(), 8);
      for (int i = 0; i < strb_q.size() && i < 8; i++)
         chk($sformatf("t3_order%0d", i), strb_q[i], 7'h10 + 7'(i));

      // sender never acknowledges: retry every 17 cycles, no extra pop
      clr_log();
      model_en = 1'b0;
      push(7'h2A);
      for (int k = 0; k < 80 && strb_q.size() < 3; k++) cyc();
      chk("t4_retries", strb_q.size(), 3);
      chk("t4_gap_a", strb_cyc[1] - strb_cyc[0], 17);
      chk("t4_gap_b", strb_cyc[2] - strb_cyc[1], 17);
      chk("t4_same_data_a", strb_q[1], 7'h2A);
      chk("t4_same_data_b", strb_q[2], 7'h2A);
      chk("t4_count_no_pop", count, 4'd0);
      model_en = 1'b1;
      run(40);

      // reset during the second character's WAIT_DONE
      clr_log();
      push(7'h21);
      push(7'h22);
      push(7'h23);
      push(7'h24);
      for (int k = 0; k < 60 && strb_q.size() < 2; k++) cyc();
      chk("t5_second_issued", strb_q.size(), 2);
      run(5);
      chk("t5_count_before_rst", count, 4'd2);
      rstN = 1'b0;
      busy_cnt = 0;
      busy = 1'b0;
      #1;
      chk("t5_rst_strobe", send_new_data, 1'b0);
      chk("t5_rst_count", count, 4'd0);
      chk("t5_rst_ready", in_ready, 1'b1);
      run(2);
      rstN = 1'b1;
      clr_log();
      run(30);
      chk("t5_silent_after_rst", strb_q.size(), 0);
      push(7'h33);
      cyc();
      chk("t5_new_strobe", send_new_data, 1'b1);
      chk("t5_new_data", send_data, 7'h33);
      run(15);

      // simultaneous push and pop at count 1, then 20 more through the wrap
      clr_log();
      exp_q.delete();
      force_busy = 1'b1;
      busy = 1'b1;
      push(7'h05);
      chk("t6_count_one", count, 4'd1);
      force_busy = 1'b0;
      busy = (busy_cnt != 0);
      push(7'h06);
      chk("t6_push_pop_count", count, 4'd1);
      chk("t6_pop_strobe", send_new_data, 1'b1);
      chk("t6_pop_data", send_data, 7'h05);
      exp_q.push_back(7'h05);
      exp_q.push_back(7'h06);
      for (int i = 0; i < 20; i++) begin
         for (int w = 0; w < 100 && !in_ready; w++) cyc();
         push(7'h40 + 7'(i));
         exp_q.push_back(7'h40 + 7'(i));
      end
      for (int k = 0; k < 600 && strb_q.size() < 22; k++) cyc();
      run(15);
      chk("t6_total_strobes", strb_q.size(), 22);
      for (int i = 0; i < strb_q.size() && i < 22; i++)
         chk($sformatf("t6_order%0d", i), strb_q[i], exp_q[i]);
      chk("t6_count_end", count, 4'd0);

      chk("stable_while_busy", stab_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
